matrix_op_sequencer: RTL and testbench
======================================

// Module: matrix_op_sequencer
// PURPOSE
//  Command-driven controller for the element-wise matrix datapath: accepts one op
//  (ADD/SUB/COPY/TRANSPOSE) plus dims, walks row-major (m,n) addresses over two
//  source mn_matrix banks, combines each element pair and writes to a destination bank.
//  Replaces ad-hoc per-op sequencing; one op in flight, strobe-driven, one result/cycle.
// PARAMETERS
//  DW       32   element width (bits)
//  AW       8    dimension/address width
//  MAX_DIM  128  largest legal m or n
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_op     in   2       00 ADD, 01 SUB, 10 COPY, 11 TRANSPOSE
//  m1_dim     in   AW      rows of source 1 (result dims are taken from m1/n1)
//  n1_dim     in   AW      cols of source 1
//  m2_dim     in   AW      rows of source 2 (checked only with DIM_CHECK_EN)
//  n2_dim     in   AW      cols of source 2 (checked only with DIM_CHECK_EN)
//  rd_en      out  1       read strobe to both source banks
//  m_addr     out  AW      source row address
//  n_addr     out  AW      source col address
//  data1_in   in   DW      source-1 element, valid 1 cycle after rd_en
//  data2_in   in   DW      source-2 element, valid 1 cycle after rd_en
//  wr_en      out  1       destination write strobe
//  wr_m_addr  out  AW      destination row
//  wr_n_addr  out  AW      destination col
//  wr_data    out  DW      result element
//  busy       out  1       high while not IDLE
//  done       out  1       one-cycle pulse at op completion
//  err        out  1       one-cycle pulse with done on rejected op
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): state IDLE; all outputs 0 except
//    cmd_ready=1; in-flight element and partial result lost, no done pulse.
//  - FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE. Dims and op latched at accept;
//    later input changes ignored. cmd_valid outside IDLE ignored (cmd_ready=0).
//  - IDLE: m_addr=n_addr=0. On accept: m==0 or n==0 -> DONE (no rd/wr); else ISSUE.
//  - ISSUE: rd_en=1 each cycle; n_addr++; at n_addr==n-1, n_addr<=0 and m_addr++;
//    after issuing (m-1,n-1) -> DRAIN. Exactly m*n reads, no gaps.
//  - Write stage (1-cycle read latency): wr_en/wr_* are rd_en/addresses delayed 1 cycle;
//    wr_data: ADD d1+d2, SUB d1-d2 (both mod 2^DW, no carry/borrow out),
//    COPY d1, TRANSPOSE d1 with wr_m_addr=n_addr_d, wr_n_addr=m_addr_d.
//  - DRAIN: last write occurs; -> DONE. DONE: done=1 one cycle; -> IDLE.
//  - Latency: accept at edge C; rd_en cycles C+1..C+m*n; writes C+2..C+1+m*n;
//    done at C+2+m*n; cmd_ready high again at C+3+m*n (no back-to-back overlap).
//  - Addresses never exceed m-1 / n-1; no wrap beyond last element.
// CONFIGURATION
//  DIM_CHECK_EN defined: on accept, ADD/SUB with (m1!=m2 or n1!=n2), or any op with
//    m1 or n1 > MAX_DIM, is rejected: no rd_en/wr_en, go to DONE, done=err=1 at C+1.
//  DIM_CHECK_EN undefined: m2/n2 ignored, no MAX_DIM check, err tied 0.
// TESTING
//  1 ADD 2x3, d1=k, d2=10k (k=element idx) -> 6 writes row-major, wr_data=11k, done at C+8.
//  2 SUB 1x1, d1=0, d2=1 -> single write wr_data=32'hFFFF_FFFF, err=0.
//  3 TRANSPOSE 2x3 -> writes to (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), data = d1.
//  4 ADD m1=0 -> no rd_en/wr_en, done at C+1, cmd_ready back next cycle.
//  5 ADD m1=2,m2=3: DIM_CHECK_EN -> done&err at C+1, no writes; without -> 2xn1 op runs.
//  6 reset_n low mid-ISSUE of 4x4, cmd_valid pulsed while busy -> outputs 0, cmd_ready=1,
//    no done; busy-time command never executed; fresh 1x2 ADD then completes normally.

Source files
------------

// File: rtl/matrix_op_sequencer.sv
// Element-wise matrix op sequencer: walks row-major (m,n) reads over two source banks and writes combined results.
// Optional DIM_CHECK_EN rejects mismatched ADD/SUB dims and dims above MAX_DIM.
module matrix_op_sequencer #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int MAX_DIM = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] m1_dim,
  input  logic [AW-1:0] n1_dim,
  input  logic [AW-1:0] m2_dim,
  input  logic [AW-1:0] n2_dim,
  output logic          rd_en,
  output logic [AW-1:0] m_addr,
  output logic [AW-1:0] n_addr,
  input  logic [DW-1:0] data1_in,
  input  logic [DW-1:0] data2_in,
  output logic          wr_en,
  output logic [AW-1:0] wr_m_addr,
  output logic [AW-1:0] wr_n_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] OP_ADD       = 2'b00;
  localparam logic [1:0] OP_SUB       = 2'b01;
  localparam logic [1:0] OP_COPY      = 2'b10;
  localparam logic [1:0] OP_TRANSPOSE = 2'b11;

`ifdef DIM_CHECK_EN
  localparam bit DIM_CHECK = 1'b1;
`else
  localparam bit DIM_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    op_reg;
  logic [AW-1:0] m_dim_reg, n_dim_reg;
  logic [AW-1:0] m_addr_reg, n_addr_reg;
  logic          wr_en_reg;
  logic [AW-1:0] wr_m_reg, wr_n_reg;
  logic          err_reg;

  logic accept, zero_dims, reject, row_end, last_elem;

  assign accept    = cmd_valid && (state_reg == IDLE);
  assign zero_dims = (m1_dim == '0) || (n1_dim == '0);
  // With DIM_CHECK cleared this folds to 0, which keeps err permanently low.
  assign reject    = DIM_CHECK &&
                     ((((cmd_op == OP_ADD) || (cmd_op == OP_SUB)) &&
                       ((m1_dim != m2_dim) || (n1_dim != n2_dim))) ||
                      (32'(m1_dim) > MAX_DIM) || (32'(n1_dim) > MAX_DIM));
  assign row_end   = (n_addr_reg == n_dim_reg - AW'(1));
  assign last_elem = row_end && (m_addr_reg == m_dim_reg - AW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (reject || zero_dims) ? DONE : ISSUE;
      ISSUE:   if (last_elem) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    rd_en     = (state_reg == ISSUE);
    done      = (state_reg == DONE);
    err       = (state_reg == DONE) && err_reg;
  end

  // Command latch and address walker; addresses return to 0 after the last element.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= OP_ADD;
      m_dim_reg  <= '0;
      n_dim_reg  <= '0;
      m_addr_reg <= '0;
      n_addr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= cmd_op;
        m_dim_reg <= m1_dim;
        n_dim_reg <= n1_dim;
        err_reg   <= reject;
      end
      if (state_reg == ISSUE) begin
        if (row_end) begin
          n_addr_reg <= '0;
          m_addr_reg <= last_elem ? '0 : m_addr_reg + AW'(1);
        end else begin
          n_addr_reg <= n_addr_reg + AW'(1);
        end
      end else begin
        m_addr_reg <= '0;
        n_addr_reg <= '0;
      end
    end
  end

  // Write stage lines up with the one-cycle source read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_reg <= 1'b0;
      wr_m_reg  <= '0;
      wr_n_reg  <= '0;
    end else begin
      wr_en_reg <= (state_reg == ISSUE);
      if (op_reg == OP_TRANSPOSE) begin
        wr_m_reg <= n_addr_reg;
        wr_n_reg <= m_addr_reg;
      end else begin
        wr_m_reg <= m_addr_reg;
        wr_n_reg <= n_addr_reg;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    if (wr_en_reg) begin
      case (op_reg)
        OP_ADD:  wr_data = data1_in + data2_in;
        OP_SUB:  wr_data = data1_in - data2_in;
        default: wr_data = data1_in;
      endcase
    end
  end

  assign m_addr    = m_addr_reg;
  assign n_addr    = n_addr_reg;
  assign wr_en     = wr_en_reg;
  assign wr_m_addr = wr_m_reg;
  assign wr_n_addr = wr_n_reg;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scoreboard bench for matrix_op_sequencer: directed cases plus random ops against a queue-based reference model.
module tb_matrix_op_sequencer;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] m1_dim = '0, n1_dim = '0, m2_dim = '0, n2_dim = '0;
  logic          rd_en;
  logic [AW-1:0] m_addr, n_addr;
  logic [DW-1:0] data1_in = '0, data2_in = '0;
  logic          wr_en;
  logic [AW-1:0] wr_m_addr, wr_n_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, err;

  matrix_op_sequencer #(.DW(DW), .AW(AW), .MAX_DIM(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .m1_dim(m1_dim), .n1_dim(n1_dim), .m2_dim(m2_dim), .n2_dim(n2_dim),
    .rd_en(rd_en), .m_addr(m_addr), .n_addr(n_addr),
    .data1_in(data1_in), .data2_in(data2_in),
    .wr_en(wr_en), .wr_m_addr(wr_m_addr), .wr_n_addr(wr_n_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      = 0;
  int rd_cnt   = 0;

  always @(posedge clk) cnt <= cnt + 1;

  logic [DW-1:0] bank1 [256];
  logic [DW-1:0] bank2 [256];

  function automatic int idx(input logic [AW-1:0] m, input logic [AW-1:0] n);
    return int'({m[3:0], n[3:0]});
  endfunction

  // Source banks: one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      data1_in <= bank1[idx(m_addr, n_addr)];
      data2_in <= bank2[idx(m_addr, n_addr)];
    end
  end

  typedef struct { int cyc; logic [AW-1:0] m; logic [AW-1:0] n; logic [DW-1:0] d; } wr_t;
  typedef struct { int cyc; logic e; int rds; } done_t;
  wr_t   wq[$];
  done_t dq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  function automatic bit exp_reject(input int op, input int m1, input int n1, input int m2, input int n2);
`ifdef DIM_CHECK_EN
    return ((op < 2) && ((m1 != m2) || (n1 != n2))) || (m1 > 128) || (n1 > 128);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (!reset_n) begin
      rd_cnt = 0;
    end else begin
      if (rd_en) rd_cnt++;
      check("ready_vs_busy", 64'(cmd_ready), 64'(!busy));
      if (wr_en) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 64'(1), 64'(0));
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", 64'({wr_m_addr, wr_n_addr}), 64'({w.m, w.n}));
          check("wr_data", 64'(wr_data), 64'(w.d));
          check("wr_cycle", 64'(cnt), 64'(w.cyc));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          done_t e;
          e = dq.pop_front();
          check("done_cycle", 64'(cnt), 64'(e.cyc));
          check("done_err", 64'(err), 64'(e.e));
          check("read_count", 64'(rd_cnt), 64'(e.rds));
        end
        rd_cnt = 0;
      end else begin
        check("err_without_done", 64'(err), 64'(0));
      end
    end
  end

  // fill: 0 random, 1 d1=k/d2=10k, 2 d1=0/d2=1
  task automatic do_op(input int op, input int m1, input int n1, input int m2, input int n2, input int fill);
    int guard;
    int c;
    int k;
    bit rej;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        case (fill)
          1:       begin bank1[i*16+j] = 32'(i*n1+j); bank2[i*16+j] = 32'(10*(i*n1+j)); end
          2:       begin bank1[i*16+j] = 32'd0;       bank2[i*16+j] = 32'd1; end
          default: begin bank1[i*16+j] = $urandom;    bank2[i*16+j] = $urandom; end
        endcase
      end
    end
    c   = cnt + 1;
    rej = exp_reject(op, m1, n1, m2, n2);
    if (rej || m1 == 0 || n1 == 0) begin
      dq.push_back('{c, rej, 0});
    end else begin
      k = 0;
      for (int i = 0; i < m1; i++) begin
        for (int j = 0; j < n1; j++) begin
          wr_t w;
          logic [DW-1:0] a, b;
          a = bank1[i*16+j];
          b = bank2[i*16+j];
          w.cyc = c + 1 + k;
          w.m = (op == 3) ? AW'(j) : AW'(i);
          w.n = (op == 3) ? AW'(i) : AW'(j);
          w.d = (op == 0) ? a + b : (op == 1) ? a - b : a;
          wq.push_back(w);
          k++;
        end
      end
      dq.push_back('{c + m1*n1 + 1, 1'b0, m1*n1});
    end
    $display("op=%0d m1=%0d n1=%0d m2=%0d n2=%0d accept_cycle=%0d reject=%0b", op, m1, n1, m2, n2, c, rej);
    cmd_valid = 1'b1;
    cmd_op = 2'(op);
    m1_dim = AW'(m1); n1_dim = AW'(n1); m2_dim = AW'(m2); n2_dim = AW'(n2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3));
    m1_dim = AW'($urandom_range(0, 9)); n1_dim = AW'($urandom_range(0, 9));
    m2_dim = AW'($urandom_range(0, 9)); n2_dim = AW'($urandom_range(0, 9));
  endtask

  initial begin
    int guard;
    int m, n, m2, n2;
    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_outputs", 64'({rd_en, wr_en, busy, done, err}), 64'(0));
    check("rst_addrs", 64'({m_addr, n_addr, wr_m_addr, wr_n_addr}), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    do_op(0, 2, 3, 2, 3, 1);   // ADD 2x3, results 11k
    do_op(1, 1, 1, 1, 1, 2);   // SUB 0-1 wraps
    do_op(3, 2, 3, 2, 3, 0);   // TRANSPOSE 2x3
    do_op(0, 0, 3, 0, 3, 0);   // zero rows
    do_op(2, 4, 0, 4, 0, 0);   // zero cols
    do_op(0, 2, 2, 3, 2, 0);   // mismatched dims

    // Reset mid-ISSUE with a command offered while busy.
    do_op(0, 4, 4, 4, 4, 0);
    repeat (4) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; m1_dim = 8'd1; n1_dim = 8'd1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    wq.delete();
    dq.delete();
    #1;
    check("mid_rst_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_outputs", 64'({rd_en, wr_en, busy, done, err}), 64'(0));
    check("mid_rst_addrs", 64'({m_addr, n_addr, wr_m_addr, wr_n_addr, wr_data}), 64'(0));
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", 64'({busy, cmd_ready}), 64'({1'b0, 1'b1}));
    do_op(0, 1, 2, 1, 2, 0);

    for (int t = 0; t < 25; t++) begin
      m = $urandom_range(0, 5);
      n = $urandom_range(0, 5);
      m2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : m;
      n2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : n;
      do_op(int'($urandom_range(0, 3)), m, n, m2, n2, 0);
    end

    guard = 0;
    while ((wq.size() != 0 || dq.size() != 0 || busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("pending_writes", 64'(wq.size()), 64'(0));
    check("pending_dones", 64'(dq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
